// File: rtl/cpu_mul_pkg.sv
// Shared types and constants for the iterative 32x32 multiply controller.
// Partial products are indexed {a_half, b_half}, so the index bits pick the operand halves directly.
package cpu_mul_pkg;

    typedef enum logic [1:0] {
        MUL_OP_MUL = 2'b00,
        MUL_OP_XUU = 2'b01,
        MUL_OP_XSU = 2'b10,
        MUL_OP_XSS = 2'b11
    } mul_op_e;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        CORR,
        DONE
    } mul_state_e;

    localparam logic [1:0] PP_LL = 2'd0;
    localparam logic [1:0] PP_LH = 2'd1;
    localparam logic [1:0] PP_HL = 2'd2;
    localparam logic [1:0] PP_HH = 2'd3;

    localparam int PP_LL_SHIFT = 0;
    localparam int PP_LH_SHIFT = 16;
    localparam int PP_HL_SHIFT = 16;
    localparam int PP_HH_SHIFT = 32;

    function automatic logic [63:0] pp_align(input logic [1:0] idx, input logic [31:0] prod);
        logic [63:0] wide;
        wide = {32'b0, prod};
        case (idx)
            PP_LL:   return wide << PP_LL_SHIFT;
            PP_LH:   return wide << PP_LH_SHIFT;
            PP_HL:   return wide << PP_HL_SHIFT;
            default: return wide << PP_HH_SHIFT;
        endcase
    endfunction

endpackage

// File: rtl/mul16_reg.sv
// Registered 16x16 unsigned multiplier with MUL_LAT pipeline stages.
// Intended to map onto a single DSP block.
module mul16_reg #(
    parameter int MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        ena,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);

    logic [31:0] stage [MUL_LAT];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int s = 0; s < MUL_LAT; s++) stage[s] <= '0;
        end else if (ena) begin
            stage[0] <= 32'(a) * 32'(b);
            for (int s = 1; s < MUL_LAT; s++) stage[s] <= stage[s-1];
        end
    end

    assign p = stage[MUL_LAT-1];

endmodule

// File: rtl/cpu_mul_seq.sv
// Iterative 32x32 multiply controller: one shared 16x16 multiplier, 64-bit accumulator,
// signed correction at the end, valid/ready handshake on request and response sides.
module cpu_mul_seq
    import cpu_mul_pkg::*;
#(
    parameter int MUL_LAT  = 1,
    parameter int RESULT_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [31:0]         req_src1,
    input  logic [31:0]         req_src2,
    input  logic                flush,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [RESULT_W-1:0] rsp_data,
    output logic                busy
);

    localparam logic [1:0] DRAIN_LAST = 2'(MUL_LAT - 1);

    mul_state_e  state;
    mul_op_e     op_q;
    logic [31:0] src1_q;
    logic [31:0] src2_q;
    logic [1:0]  idx;
    logic [1:0]  drain_cnt;
    logic [63:0] acc;
    logic [63:0] corr;
    logic [63:0] acc_corr;

    logic               mul_ena;
    logic               mul_clr;
    logic [15:0]        mul_a;
    logic [15:0]        mul_b;
    logic [31:0]        mul_p;
    logic [MUL_LAT-1:0] vld_pipe;
    logic [1:0]         idx_pipe [MUL_LAT];

    logic       accept;
    logic [1:0] last_idx;

    assign req_ready = (state == IDLE) || ((state == DONE) && rsp_ready);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready && !flush;
    assign last_idx  = (op_q == MUL_OP_MUL) ? PP_HL : PP_HH;

    assign mul_ena = (state == ISSUE) || (state == DRAIN);
    assign mul_clr = !reset_n || flush;
    assign mul_a   = idx[1] ? src1_q[31:16] : src1_q[15:0];
    assign mul_b   = idx[0] ? src2_q[31:16] : src2_q[15:0];

    mul16_reg #(.MUL_LAT(MUL_LAT)) u_mul (
        .clk (clk),
        .clr (mul_clr),
        .ena (mul_ena),
        .a   (mul_a),
        .b   (mul_b),
        .p   (mul_p)
    );

    // Tags travel alongside the multiplier so each product lands at its own shift.
    always_ff @(posedge clk) begin
        if (mul_clr) begin
            vld_pipe <= '0;
            for (int s = 0; s < MUL_LAT; s++) idx_pipe[s] <= '0;
        end else if (mul_ena) begin
            vld_pipe[0] <= (state == ISSUE);
            idx_pipe[0] <= idx;
            for (int s = 1; s < MUL_LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                idx_pipe[s] <= idx_pipe[s-1];
            end
        end
    end

    // Unsigned product minus operand<<32 for each negative signed operand gives the signed product.
    always_comb begin
        corr = '0;
        if (((op_q == MUL_OP_XSU) || (op_q == MUL_OP_XSS)) && src1_q[31])
            corr = corr + {src2_q, 32'b0};
        if ((op_q == MUL_OP_XSS) && src2_q[31])
            corr = corr + {src1_q, 32'b0};
        acc_corr = acc - corr;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            acc       <= '0;
            op_q      <= MUL_OP_MUL;
            src1_q    <= '0;
            src2_q    <= '0;
            idx       <= '0;
            drain_cnt <= '0;
        end else if (flush) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            acc       <= '0;
        end else begin
            if (mul_ena && vld_pipe[MUL_LAT-1])
                acc <= acc + pp_align(idx_pipe[MUL_LAT-1], mul_p);

            case (state)
                IDLE: ;
                ISSUE: begin
                    if (idx == last_idx) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) state <= CORR;
                    else drain_cnt <= drain_cnt + 2'd1;
                end
                CORR: begin
                    acc       <= acc_corr;
                    rsp_data  <= (op_q == MUL_OP_MUL) ? acc_corr[31:0] : acc_corr[63:32];
                    rsp_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Accept overrides the DONE->IDLE move for back-to-back requests.
            if (accept) begin
                op_q   <= mul_op_e'(req_op);
                src1_q <= req_src1;
                src2_q <= req_src2;
                idx    <= PP_LL;
                acc    <= '0;
                state  <= ISSUE;
            end
        end
    end

endmodule

// File: tb/tb_cpu_mul_seq.sv
// Directed self-checking bench for cpu_mul_seq with hand-computed expected results and latencies.
module tb_cpu_mul_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    cpu_mul_seq #(.MUL_LAT(1), .RESULT_W(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_src1  (req_src1),
        .req_src2  (req_src2),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic waitRsp(output int edges);
        edges = 0;
        while (!rsp_valid && edges < 20) begin
            tick();
            edges++;
        end
    endtask

    task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expected, input int lat);
        int edges;
        applyStimulus(op, a, b);
        waitRsp(edges);
        checkOutput({tag, " data"}, 64'(rsp_data), 64'(expected));
        checkOutput({tag, " latency"}, 64'(edges), 64'(lat));
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int edges;
        logic seen;

        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_src1  = '0;
        req_src2  = '0;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        checkOutput("reset req_ready", 64'(req_ready), 64'd1);
        checkOutput("reset rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("reset rsp_data", 64'(rsp_data), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);

        runOp("mul small", 2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 5);
        runOp("xuu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 6);
        runOp("xss minus1", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 6);
        runOp("xsu minus1x2", 2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 6);
        runOp("xss minint", 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 6);
        runOp("mul zero", 2'b00, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 5);

        // Response held under back-pressure, then a back-to-back accept.
        rsp_ready = 1'b0;
        applyStimulus(2'b10, 32'hFFFF_FFFF, 32'h0000_0002);
        waitRsp(edges);
        checkOutput("hold latency", 64'(edges), 64'd6);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("hold data", 64'(rsp_data), 64'hFFFF_FFFF);
            checkOutput("hold req_ready", 64'(req_ready), 64'd0);
            checkOutput("hold rsp_valid", 64'(rsp_valid), 64'd1);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_src1  = 32'd3;
        req_src2  = 32'd4;
        #1;
        checkOutput("b2b req_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        checkOutput("b2b busy", 64'(busy), 64'd1);
        checkOutput("b2b rsp_valid drop", 64'(rsp_valid), 64'd0);
        waitRsp(edges);
        checkOutput("b2b data", 64'(rsp_data), 64'h0000_000C);
        checkOutput("b2b latency", 64'(edges), 64'd5);
        tick();

        // Flush mid-issue discards the operation.
        applyStimulus(2'b01, 32'hDEAD_BEEF, 32'h1234_5678);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush busy", 64'(busy), 64'd0);
        checkOutput("flush rsp_valid", 64'(rsp_valid), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | rsp_valid;
        end
        checkOutput("flush no rsp", 64'(seen), 64'd0);
        runOp("post-flush mul", 2'b00, 32'd7, 32'd6, 32'h0000_002A, 5);

        // A request presented together with flush is dropped.
        req_valid = 1'b1;
        flush     = 1'b1;
        req_op    = 2'b00;
        tick();
        req_valid = 1'b0;
        flush     = 1'b0;
        checkOutput("flush blocks accept", 64'(busy), 64'd0);

        // Reset during DONE; no change until the clock edge.
        rsp_ready = 1'b0;
        applyStimulus(2'b11, 32'h8000_0000, 32'h8000_0000);
        waitRsp(edges);
        checkOutput("pre-reset data", 64'(rsp_data), 64'h4000_0000);
        reset_n = 1'b0;
        #2;
        checkOutput("reset no-edge rsp_valid", 64'(rsp_valid), 64'd1);
        checkOutput("reset no-edge rsp_data", 64'(rsp_data), 64'h4000_0000);
        checkOutput("reset no-edge req_ready", 64'(req_ready), 64'd0);
        tick();
        reset_n = 1'b1;
        checkOutput("mid reset rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("mid reset rsp_data", 64'(rsp_data), 64'd0);
        checkOutput("mid reset req_ready", 64'(req_ready), 64'd1);
        checkOutput("mid reset busy", 64'(busy), 64'd0);
        rsp_ready = 1'b1;
        runOp("post-reset xsu", 2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
